mc_ctrl_fsm: RTL
================

// Module: mc_ctrl_fsm
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core (lw, sw, R, I-ALU, beq/bne/blt/bge, jal, jalr, lui).
//  Sequences the shared datapath (one ALU, one unified memory) over 3-5 states per instruction.
//  Waits on a memory ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of the InstRet retired-instruction counter (wraps mod 2^CNT_W)
// PORTS
//  clk        in   1      core clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high; one clock; no other clocks/resets
//  op         in   7      instr[6:0] from the instruction register
//  MemReady   in   1      memory has completed the access issued this cycle
//  MemReq     out  1      memory access request (held until MemReady)
//  AdrSrc     out  1      0: PC, 1: ALUOut drives the memory address
//  MemWrite   out  1      store strobe (valid only with MemReq)
//  IRWrite    out  1      load the IR and OldPC
//  PCUpdate   out  1      unconditional PC write
//  Branch     out  1      PC write if the branch unit condition is true
//  Jalr       out  1      clear target bit 0 on this PC write
//  RegWrite   out  1      register file write enable
//  ResultSrc  out  2      00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//  ALUSrcA    out  2      00 PC, 01 OldPC, 10 RegA
//  ALUSrcB    out  2      00 RegB, 01 ImmExt, 10 const 4
//  ALUOp      out  2      00 add, 01 branch compare (funct3), 10 funct decode
//  ImmSrc     out  3      000 I, 001 S, 010 B, 011 J, 100 U; comb from op, xxx for R-type
//  InstrDone  out  1      1-cycle pulse in the final cycle of each instruction
//  Illegal    out  1      high while in TRAP
//  InstRet    out  CNT_W  count of InstrDone pulses
// BEHAVIOUR
//  - Reset: next state = FETCH and InstRet = 0. While reset is high, force every strobe
//    (MemReq, MemWrite, IRWrite, PCUpdate, Branch, RegWrite, InstrDone, Illegal) to 0.
//  - Reset dominates mid-instruction: a pending MemWrite/RegWrite is dropped the cycle reset is seen.
//  - Outputs are Moore by state. Exception: IRWrite/PCUpdate in FETCH = MemReady. Unlisted outputs = 0.
//  - FETCH: MemReq, AdrSrc=0, A=00, B=10, ALUOp=00, Res=10.
//      Stay while !MemReady; on MemReady go to DECODE (IR loaded and PC+=4 exactly once).
//  - DECODE: A=01, B=01, ALUOp=00 (ALUOut=branch/jal target). Next state by op:
//      0000011/0100011 MEMADR; 0110011 EXR; 0010011 EXI; 1100011 BRANCH; 1101111 JAL;
//      1100111 JALRADR; 0110111 LUI; else TRAP.
//  - MEMADR: A=10, B=01, ALUOp=00. Next: lw MEMREAD, sw MEMWRITE.
//  - MEMREAD: MemReq, AdrSrc=1. Wait on MemReady, then MEMWB.
//  - MEMWB: Res=01, RegWrite, InstrDone. Next FETCH.
//  - MEMWRITE: MemReq, AdrSrc=1, MemWrite. On MemReady: InstrDone, next FETCH.
//  - EXR: A=10, B=00, ALUOp=10. Next ALUWB.
//  - EXI: A=10, B=01, ALUOp=10. Next ALUWB.
//  - ALUWB: Res=00, RegWrite, InstrDone. Next FETCH.
//  - BRANCH: A=10, B=00, ALUOp=01, Res=00, Branch, InstrDone. Next FETCH.
//  - JAL: A=01, B=10, ALUOp=00, Res=00, PCUpdate. Next ALUWB (rd = OldPC+4).
//  - JALRADR: A=10, B=01, ALUOp=00. Next JALRPC.
//  - JALRPC: A=01, B=10, Res=00, PCUpdate, Jalr. Next ALUWB.
//  - LUI: Res=11, RegWrite, InstrDone. Next FETCH.
//  - TRAP: Illegal=1, all strobes 0; sticky until reset.
//  - Memory handshake: MemReady is ignored outside FETCH/MEMREAD/MEMWRITE.
//    MemReady may be high in the first cycle of the state (0-wait memory).
//  - InstRet increments on InstrDone and wraps from all-ones to 0. Pulse-to-count latency is 1 cycle.
//  - CPI: lw 5; sw, R, I, jal, jalr(4) ... exact: lw 5, sw 4, R/I 4, beq 3, jal 4, jalr 5, lui 3
//    (each + memory waits).
// STRUCTURE
//  - Package rv_mc_pkg: state enum, opcode localparams, and ALUSrcA/B, ResultSrc, ImmSrc, ALUOp encodings.
//  - Sub-module immsrc_dec: combinational op -> ImmSrc.
//  - Top: state register, next-state case, output case, InstRet counter.
// TESTING
//  - Reset then `lw` (0000011), MemReady=1 always: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB.
//      Expect RegWrite/Res=01 only in cycle 5; InstRet 0->1.
//  - `sw` with MemReady low for 3 cycles in MEMWRITE: MemReq+MemWrite held 4 cycles, AdrSrc=1.
//      Expect exactly one InstrDone.
//  - FETCH with MemReady delayed 2 cycles: IRWrite/PCUpdate = 0,0,1 and exactly one DECODE entry.
//  - `jalr` (1100111): JALRPC asserts PCUpdate+Jalr, then ALUWB with RegWrite, Res=00, A=01, B=10.
//  - op=7'b1111111: TRAP, Illegal=1 held 10 cycles with no strobes; reset -> FETCH, InstRet=0.
//  - Reset asserted in MEMWRITE with MemReady=1: no InstrDone, MemWrite=0 that cycle.
//      InstRet wraps with CNT_W=4 after 16 beqs.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Holds the state codes, opcode constants, datapath mux encodings and the
// packed control bundle that the main FSM builds each cycle.
package rv_mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXR      = 4'd6;
    localparam state_t S_EXI      = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_JALRADR  = 4'd11;
    localparam state_t S_JALRPC   = 4'd12;
    localparam state_t S_LUI      = 4'd13;
    localparam state_t S_TRAP     = 4'd14;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       jalr;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_immsrc_dec.sv
// Immediate-format decoder: maps the opcode to the ImmSrc selection used by
// the immediate extender. Purely combinational.
//   op       in  7  instr[6:0]
//   imm_src  out 3  000 I, 001 S, 010 B, 011 J, 100 U
module immsrc_dec
    import rv_mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_LW, OP_I, OP_JALR: imm_src = IMM_I;
            OP_SW:                imm_src = IMM_S;
            OP_BR:                imm_src = IMM_B;
            OP_JAL:               imm_src = IMM_J;
            OP_LUI:               imm_src = IMM_U;
            // R-type has no immediate; I-format is a harmless default
            default:              imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Sequences the shared ALU
// and unified memory through 3-5 states per instruction, stalls on the
// memory ready handshake and counts retired instructions.
// Ports:
//   clk, reset (sync, active-high)      op: instr[6:0]     MemReady: memory done
//   MemReq/AdrSrc/MemWrite              memory control
//   IRWrite/PCUpdate/Branch/Jalr        IR and PC update control
//   RegWrite/ResultSrc                  register write-back control
//   ALUSrcA/ALUSrcB/ALUOp/ImmSrc        ALU operand and operation select
//   InstrDone  pulse in last cycle of an instruction
//   Illegal    high while trapped on an unknown opcode
//   InstRet    retired-instruction counter (wraps)
module mc_ctrl_fsm
    import rv_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             Jalr,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             InstrDone,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;

    immsrc_dec u_immsrc_dec (
        .op      (op),
        .imm_src (ImmSrc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (MemReady) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXR;
                    OP_I:         state_next = S_EXI;
                    OP_BR:        state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    OP_JALR:      state_next = S_JALRADR;
                    OP_LUI:       state_next = S_LUI;
                    default:      state_next = S_TRAP;
                endcase
            end
            // Only lw/sw reach here, so anything not a store is a load
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (MemReady) state_next = S_FETCH;
            S_EXR:      state_next = S_ALUWB;
            S_EXI:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_JALRADR:  state_next = S_JALRPC;
            S_JALRPC:   state_next = S_ALUWB;
            S_LUI:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl_raw = '0;
        case (state)
            S_FETCH: begin
                ctrl_raw.mem_req    = 1'b1;
                ctrl_raw.adr_src    = 1'b0;
                ctrl_raw.alu_src_a  = SRCA_PC;
                ctrl_raw.alu_src_b  = SRCB_FOUR;
                ctrl_raw.alu_op     = ALUOP_ADD;
                ctrl_raw.result_src = RES_ALURESULT;
                // IR load and PC+4 happen exactly once, on the accepting cycle
                ctrl_raw.ir_write   = MemReady;
                ctrl_raw.pc_update  = MemReady;
            end
            S_DECODE: begin
                ctrl_raw.alu_src_a = SRCA_OLDPC;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_JALRADR: begin
                ctrl_raw.alu_src_a = SRCA_REGA;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_raw.mem_req = 1'b1;
                ctrl_raw.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl_raw.result_src = RES_DATA;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_raw.mem_req    = 1'b1;
                ctrl_raw.adr_src    = 1'b1;
                ctrl_raw.mem_write  = 1'b1;
                ctrl_raw.instr_done = MemReady;
            end
            S_EXR: begin
                ctrl_raw.alu_src_a = SRCA_REGA;
                ctrl_raw.alu_src_b = SRCB_REGB;
                ctrl_raw.alu_op    = ALUOP_FUNCT;
            end
            S_EXI: begin
                ctrl_raw.alu_src_a = SRCA_REGA;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_raw.result_src = RES_ALUOUT;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_raw.alu_src_a  = SRCA_REGA;
                ctrl_raw.alu_src_b  = SRCB_REGB;
                ctrl_raw.alu_op     = ALUOP_BR;
                ctrl_raw.result_src = RES_ALUOUT;
                ctrl_raw.branch     = 1'b1;
                ctrl_raw.instr_done = 1'b1;
            end
            S_JAL: begin
                // ALUOut already holds the target; ALU computes OldPC+4 for rd
                ctrl_raw.alu_src_a  = SRCA_OLDPC;
                ctrl_raw.alu_src_b  = SRCB_FOUR;
                ctrl_raw.alu_op     = ALUOP_ADD;
                ctrl_raw.result_src = RES_ALUOUT;
                ctrl_raw.pc_update  = 1'b1;
            end
            S_JALRPC: begin
                ctrl_raw.alu_src_a  = SRCA_OLDPC;
                ctrl_raw.alu_src_b  = SRCB_FOUR;
                ctrl_raw.result_src = RES_ALUOUT;
                ctrl_raw.pc_update  = 1'b1;
                ctrl_raw.jalr       = 1'b1;
            end
            S_LUI: begin
                ctrl_raw.result_src = RES_IMM;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl_raw.illegal = 1'b1;
            end
            default: ctrl_raw = '0;
        endcase
    end

    // Reset wins immediately: any strobe of an in-flight instruction is dropped
    always_comb begin
        ctrl = ctrl_raw;
        if (reset) begin
            ctrl.mem_req    = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.ir_write   = 1'b0;
            ctrl.pc_update  = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.instr_done = 1'b0;
            ctrl.illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            InstRet <= '0;
        end else if (ctrl.instr_done) begin
            InstRet <= InstRet + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign MemReq    = ctrl.mem_req;
    assign AdrSrc    = ctrl.adr_src;
    assign MemWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign PCUpdate  = ctrl.pc_update;
    assign Branch    = ctrl.branch;
    assign Jalr      = ctrl.jalr;
    assign RegWrite  = ctrl.reg_write;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign InstrDone = ctrl.instr_done;
    assign Illegal   = ctrl.illegal;

endmodule
